// File: rtl/pipe_pkg.sv
// Shared types and default widths for every pipe_skid_stage instance.
package pipe_pkg;

  localparam int unsigned DEF_PAYLOAD_W = 48;
  localparam int unsigned DEF_CTRL_W    = 3;
  localparam int unsigned DEF_WE_W      = 2;
  localparam int unsigned DEF_CNT_W     = 16;

  // Bit positions inside the write-enable field.
  localparam int unsigned WE_REG = 0;
  localparam int unsigned WE_MEM = 1;

  typedef struct packed {
    logic [DEF_PAYLOAD_W-1:0] payload;
    logic [DEF_CTRL_W-1:0]    ctrl;
    logic [DEF_WE_W-1:0]      we;
  } stage_beat_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with a two-entry skid buffer, flush and
// saturating stall/flush performance counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned CTRL_W    = DEF_CTRL_W,
  parameter int unsigned WE_W      = DEF_WE_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [WE_W-1:0]      in_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [WE_W-1:0]      out_we,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [CTRL_W-1:0]    ctrl;
    logic [WE_W-1:0]      we;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  beat_t in_beat;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q, in_ready_d;
  logic  in_fire, out_fire;
  logic  stall_inc, flush_inc;

  assign in_beat   = {in_payload, in_ctrl, in_we};
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = main_valid_q & out_ready;
  assign stall_inc = main_valid_q & ~out_ready & ~flush;
  assign flush_inc = flush & (main_valid_q | skid_valid_q | in_fire);

  // Entry movement; an emptied main entry drops its write enables so out_we tracks out_valid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_d.we    = '0;
      skid_d.we    = '0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_d = in_beat;
        end
      end else if (in_fire) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
        main_d.we    = '0;
      end
    end else if (in_fire) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_payload = main_q.payload;
  assign out_ctrl    = main_q.ctrl;
  assign out_we      = main_q.we;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (cnt_clr),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: vector table, directed corner cases
// and randomized traffic checked against a queue-based reference model.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [47:0] in_payload = '0;
  logic [2:0]  in_ctrl = '0;
  logic [1:0]  in_we = '0;

  logic        in_ready, out_valid;
  logic [47:0] out_payload;
  logic [2:0]  out_ctrl;
  logic [1:0]  out_we;
  logic [15:0] stall_cnt, flush_cnt;

  logic        in_ready_s, out_valid_s;
  logic [47:0] out_payload_s;
  logic [2:0]  out_ctrl_s;
  logic [1:0]  out_we_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stage is a FIFO of at most two beats.
  stage_beat_t mq[$];
  bit          m_ready = 1'b0;
  int          m_stall = 0, m_flush = 0, m_stall_s = 0, m_flush_s = 0;

  always #5 clk = ~clk;

  pipe_skid_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_ctrl(in_ctrl), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_ctrl(out_ctrl), .out_we(out_we),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_skid_stage #(.CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_payload(in_payload),
    .in_ctrl(in_ctrl), .in_we(in_we),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_payload(out_payload_s),
    .out_ctrl(out_ctrl_s), .out_we(out_we_s),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // Advance the model from the current inputs, clock once, then compare everything.
  task automatic tick();
    bit fire_in, fire_out;
    stage_beat_t b;
    if (!rst) begin
      mq.delete();
      m_ready = 1'b0;
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      fire_in  = in_valid && m_ready;
      fire_out = (mq.size() > 0) && out_ready;
      if (cnt_clr) begin
        m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
      end else begin
        if ((mq.size() > 0) && !out_ready && !flush) begin
          m_stall   = sat_inc(m_stall, 65535);
          m_stall_s = sat_inc(m_stall_s, 3);
        end
        if (flush && ((mq.size() > 0) || fire_in)) begin
          m_flush   = sat_inc(m_flush, 65535);
          m_flush_s = sat_inc(m_flush_s, 3);
        end
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (fire_out) void'(mq.pop_front());
        if (fire_in) begin
          b.payload = in_payload; b.ctrl = in_ctrl; b.we = in_we;
          mq.push_back(b);
        end
      end
      m_ready = (mq.size() < 2);
    end

    @(posedge clk); #1;

    chk("m_in_ready", 64'(in_ready), 64'(m_ready));
    chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("m_flush_cnt", 64'(flush_cnt), 64'(m_flush));
    chk("m_stall_cnt_s", 64'(stall_cnt_s), 64'(m_stall_s));
    chk("m_flush_cnt_s", 64'(flush_cnt_s), 64'(m_flush_s));
    chk("m_in_ready_s", 64'(in_ready_s), 64'(m_ready));
    chk("m_out_valid_s", 64'(out_valid_s), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_out_payload", 64'(out_payload), 64'(mq[0].payload));
      chk("m_out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
      chk("m_out_we", 64'(out_we), 64'(mq[0].we));
      chk("m_out_payload_s", 64'(out_payload_s), 64'(mq[0].payload));
      chk("m_out_ctrl_s", 64'(out_ctrl_s), 64'(mq[0].ctrl));
      chk("m_out_we_s", 64'(out_we_s), 64'(mq[0].we));
    end else begin
      chk("m_out_we_idle", 64'(out_we), 64'(0));
      chk("m_out_we_idle_s", 64'(out_we_s), 64'(0));
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] ir, input bit ordy,
                       input bit fl, input bit clr, input logic [1:0] we);
    in_valid   = v;
    in_payload = {16'h0000, 16'h00C0, ir};
    in_ctrl    = ir[2:0];
    in_we      = we;
    out_ready  = ordy;
    flush      = fl;
    cnt_clr    = clr;
  endtask

  typedef struct {
    bit          v;
    logic [15:0] ir;
    bit          ordy;
    bit          exp_valid;
    logic [15:0] exp_ir;
    bit          exp_ready;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming: one beat per cycle, one-cycle latency.
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 16'h1000 + 16'(i), 1'b1, 1'b1, 16'h1000 + 16'(i), 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    // Stall: A1 held, A2 skidded, A3 blocked until release.
    tbl[9]  = '{1'b1, 16'h00A1, 1'b0, 1'b1, 16'h00A1, 1'b1};
    tbl[10] = '{1'b1, 16'h00A2, 1'b0, 1'b1, 16'h00A1, 1'b0};
    tbl[11] = '{1'b1, 16'h00A3, 1'b0, 1'b1, 16'h00A1, 1'b0};
    tbl[12] = '{1'b1, 16'h00A3, 1'b0, 1'b1, 16'h00A1, 1'b0};
    tbl[13] = '{1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A2, 1'b1};
    tbl[14] = '{1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A3, 1'b1};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};

    // 1. Reset for two cycles, then release.
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_payload", 64'(out_payload), 64'(0));
    tick();
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_flush_cnt", 64'(flush_cnt), 64'(0));
    rst = 1'b1;
    tick();
    chk("rst_release_ready", 64'(in_ready), 64'(1));
    chk("rst_release_out_we", 64'(out_we), 64'(0));

    // 2/3. Table-driven streaming and stall/skid.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].ir, tbl[i].ordy, 1'b0, 1'b0, 2'b01);
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_ir", i), 64'(out_payload[15:0]), 64'(tbl[i].exp_ir));
      chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].exp_ready));
    end
    chk("stall_cnt_3", 64'(stall_cnt), 64'(3));

    // 4. Flush with both entries full.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 2'b00); tick();
    drive(1'b1, 16'h00B1, 1'b0, 1'b0, 1'b0, 2'b11); tick();
    drive(1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0, 2'b11); tick();
    chk("full_in_ready", 64'(in_ready), 64'(0));
    drive(1'b1, 16'h00B3, 1'b0, 1'b1, 1'b0, 2'b11); tick();
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_out_we", 64'(out_we), 64'(0));
    chk("flush_cnt_1", 64'(flush_cnt), 64'(1));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    drive(1'b1, 16'h00B4, 1'b1, 1'b0, 1'b0, 2'b11); tick();
    chk("post_flush_valid", 64'(out_valid), 64'(1));
    chk("post_flush_ir", 64'(out_payload[15:0]), 64'(16'h00B4));
    chk("post_flush_we", 64'(out_we), 64'(2'b11));
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    chk("post_flush_drain", 64'(out_valid), 64'(0));

    // 5. Flush together with out_fire and in_fire.
    drive(1'b1, 16'h00C1, 1'b0, 1'b0, 1'b0, 2'b10); tick();
    chk("pre_flush_ir", 64'(out_payload[15:0]), 64'(16'h00C1));
    drive(1'b1, 16'h00C2, 1'b1, 1'b1, 1'b0, 2'b10); tick();
    chk("flush_fire_valid", 64'(out_valid), 64'(0));
    chk("flush_fire_cnt", 64'(flush_cnt), 64'(2));
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    chk("flush_fire_dropped", 64'(out_valid), 64'(0));

    // 6. Saturation of the 2-bit counter, then clear during a stall.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 2'b00); tick();
    drive(1'b1, 16'h00D1, 1'b0, 1'b0, 1'b0, 2'b01); tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_stall_s", 64'(stall_cnt_s), 64'(3));
    chk("sat_stall_wide", 64'(stall_cnt), 64'(6));
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 2'b00); tick();
    chk("clr_stall_s", 64'(stall_cnt_s), 64'(0));
    chk("clr_stall_wide", 64'(stall_cnt), 64'(0));
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 2'b00); tick();

    // Randomized traffic including flushes, clears and occasional reset.
    for (int i = 0; i < 800; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_payload = {16'($urandom), 32'($urandom)};
      in_ctrl    = 3'($urandom);
      in_we      = 2'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      cnt_clr    = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
